// File: rtl/ws2812_tx.sv
// WS2812B serial line driver: 24-bit pixels out as NRZ pulses,
// with a one-entry holding register for gapless updates.
module ws2812_tx #(
    parameter int T0H          = 8,
    parameter int T1H          = 16,
    parameter int BIT_CYCLES   = 25,
    parameter int RESET_CYCLES = 6000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] data_in,
    input  logic        latch,
    input  logic        valid,
    output logic        ready,
    output logic        led,
    output logic        busy,
    output logic        underrun
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam int RW = $clog2(RESET_CYCLES + 1);

    localparam logic [CW-1:0] T0H_C  = CW'(T0H);
    localparam logic [CW-1:0] T1H_C  = CW'(T1H);
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        LATCH
    } state_t;

    state_t        state_q, state_d;
    logic [23:0]   shift_q, shift_d;
    logic          cur_latch_q, cur_latch_d;
    logic [4:0]    bit_q, bit_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [RW-1:0] rst_q, rst_d;

    logic [23:0]   hold_data_q, hold_data_d;
    logic          hold_latch_q, hold_latch_d;
    logic          hold_full_q, hold_full_d;

    logic          ready_q, ready_d;
    logic          led_q, led_d;
    logic          busy_q, busy_d;
    logic          underrun_q, underrun_d;

    logic          load;
    logic          accept;

    assign accept = valid && ready_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cur_latch_d = cur_latch_q;
        bit_d       = bit_q;
        cyc_d       = cyc_q;
        rst_d       = rst_q;
        underrun_d  = 1'b0;
        load        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    load = 1'b1;
                end
            end
            SEND: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d = '0;
                    if (bit_q == 5'd23) begin
                        if (cur_latch_q) begin
                            state_d = LATCH;
                            rst_d   = '0;
                        end else if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d    = IDLE;
                            underrun_d = 1'b1;
                        end
                    end else begin
                        shift_d = {shift_q[22:0], 1'b0};
                        bit_d   = bit_q + 5'd1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            LATCH: begin
                if (rst_q == RST_LAST) begin
                    state_d = IDLE;
                    rst_d   = '0;
                end else begin
                    rst_d = rst_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d     = SEND;
            shift_d     = hold_data_q;
            cur_latch_d = hold_latch_q;
            bit_d       = '0;
            cyc_d       = '0;
        end
    end

    // Hold refill wins over the drain when both land on one edge.
    always_comb begin
        hold_data_d  = hold_data_q;
        hold_latch_d = hold_latch_q;
        hold_full_d  = hold_full_q;
        if (load) begin
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_data_d  = data_in;
            hold_latch_d = latch;
            hold_full_d  = 1'b1;
        end
    end

    // Outputs are computed from next state so the pin is registered
    // yet rises on the very edge a pixel is loaded.
    always_comb begin
        ready_d = !hold_full_d;
        busy_d  = (state_d != IDLE) || hold_full_d;
        led_d   = (state_d == SEND) &&
                  (cyc_d < (shift_d[23] ? T1H_C : T0H_C));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            cur_latch_q  <= 1'b0;
            bit_q        <= '0;
            cyc_q        <= '0;
            rst_q        <= '0;
            hold_data_q  <= '0;
            hold_latch_q <= 1'b0;
            hold_full_q  <= 1'b0;
            ready_q      <= 1'b0;
            led_q        <= 1'b0;
            busy_q       <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cur_latch_q  <= cur_latch_d;
            bit_q        <= bit_d;
            cyc_q        <= cyc_d;
            rst_q        <= rst_d;
            hold_data_q  <= hold_data_d;
            hold_latch_q <= hold_latch_d;
            hold_full_q  <= hold_full_d;
            ready_q      <= ready_d;
            led_q        <= led_d;
            busy_q       <= busy_d;
            underrun_q   <= underrun_d;
        end
    end

    assign ready    = ready_q;
    assign led      = led_q;
    assign busy     = busy_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_ws2812_tx.sv
// Directed bench for ws2812_tx: pulse shapes, pixel pitch,
// underrun, handshake, latch interval and mid-pixel reset.
module tb_ws2812_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] data_in;
    logic        latch;
    logic        valid;
    logic        ready;
    logic        led;
    logic        busy;
    logic        underrun;

    int n_checks = 0;
    int n_fail   = 0;
    int n_under  = 0;
    int n_acc    = 0;

    ws2812_tx dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .latch    (latch),
        .valid    (valid),
        .ready    (ready),
        .led      (led),
        .busy     (busy),
        .underrun (underrun)
    );

    always #25 clk = ~clk;

    always @(negedge clk) begin
        if (underrun) n_under++;
        if (valid && ready) n_acc++;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [23:0] d, input logic l);
        int n = 0;
        while (!ready && n < 2000) begin
            step();
            n++;
        end
        check("send_rdy_to", 32'(ready), 32'd1);
        data_in = d;
        latch   = l;
        valid   = 1'b1;
        step();
        valid   = 1'b0;
        check("rdy_after_acc", 32'(ready), 32'd0);
    endtask

    task automatic chk_pixel(input string tag, input logic [23:0] d);
        int errs = 0;
        int ups  = 0;
        for (int c = 0; c < 600; c++) begin
            logic b;
            logic e;
            b = d[23 - c / 25];
            e = ((c % 25) < (b ? 16 : 8));
            if (led !== e) errs++;
            if (underrun) ups++;
            step();
        end
        check(tag, 32'(errs), 32'd0);
        check({tag, "_nounder"}, 32'(ups), 32'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 8000) begin
            step();
            n++;
        end
        check("idle_to", 32'(busy), 32'd0);
    endtask

    initial begin
        int u0;
        int a0;
        int n;
        int errs;
        rst_n   = 1'b0;
        valid   = 1'b0;
        latch   = 1'b0;
        data_in = '0;
        step();
        step();
        check("rst_led", 32'(led), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_under", 32'(underrun), 32'd0);
        rst_n = 1'b1;
        step();
        check("ready_rise", 32'(ready), 32'd1);

        // single latched pixel, then the 6000-cycle low
        send(24'h800001, 1'b1);
        check("t1_led_at_acc", 32'(led), 32'd0);
        step();
        check("t1_ready_back", 32'(ready), 32'd1);
        chk_pixel("t1_pix", 24'h800001);
        errs = 0;
        for (int c = 0; c < 6000; c++) begin
            if (led !== 1'b0 || busy !== 1'b1) errs++;
            step();
        end
        check("t1_latch_low", 32'(errs), 32'd0);
        check("t1_busy_end", 32'(busy), 32'd0);

        // back-to-back pixels, second offered during first
        u0 = n_under;
        send(24'hFFFFFF, 1'b0);
        fork
            begin
                step();
                chk_pixel("t2_pix0", 24'hFFFFFF);
                chk_pixel("t2_pix1", 24'h000000);
            end
            send(24'h000000, 1'b1);
        join
        wait_idle();
        check("t2_no_under", 32'(n_under - u0), 32'd0);

        // underrun after an unlatched pixel with nothing queued
        u0 = n_under;
        send(24'h5A5A5A, 1'b0);
        step();
        chk_pixel("t3_pix", 24'h5A5A5A);
        check("t3_under_hi", 32'(underrun), 32'd1);
        check("t3_led_lo", 32'(led), 32'd0);
        step();
        check("t3_under_lo", 32'(underrun), 32'd0);
        check("t3_under_cnt", 32'(n_under - u0), 32'd1);
        check("t3_idle", 32'(busy), 32'd0);
        send(24'h123456, 1'b1);
        step();
        chk_pixel("t3_restart", 24'h123456);
        wait_idle();

        // valid held high across three pixels
        u0 = n_under;
        a0 = n_acc;
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    n = 0;
                    data_in = (k == 0) ? 24'hA00001 :
                              (k == 1) ? 24'h0C00F0 : 24'hF0F00F;
                    latch   = (k == 2);
                    valid   = 1'b1;
                    while (!ready && n < 2000) begin
                        step();
                        n++;
                    end
                    step();
                    check("t4_rdy_gap", 32'(ready), 32'd0);
                end
                valid = 1'b0;
            end
            begin
                step();
                step();
                chk_pixel("t4_p0", 24'hA00001);
                chk_pixel("t4_p1", 24'h0C00F0);
                chk_pixel("t4_p2", 24'hF0F00F);
            end
        join
        wait_idle();
        check("t4_accepts", 32'(n_acc - a0), 32'd3);
        check("t4_no_under", 32'(n_under - u0), 32'd0);

        // pixel offered during LATCH waits for the full low
        send(24'hAAAAAA, 1'b1);
        step();
        chk_pixel("t6_pix", 24'hAAAAAA);
        send(24'h0F0F0F, 1'b1);
        n = 0;
        while (!led && n < 7000) begin
            step();
            n++;
        end
        check("t6_rise_delay", 32'(n), 32'd6000);
        chk_pixel("t6_pix2", 24'h0F0F0F);
        wait_idle();

        // reset at bit 10 with hold full
        u0 = n_under;
        send(24'hC3C3C3, 1'b0);
        step();
        send(24'h3C3C3C, 1'b0);
        repeat (248) step();
        check("t5_busy_pre", 32'(busy), 32'd1);
        check("t5_ready_pre", 32'(ready), 32'd0);
        rst_n = 1'b0;
        step();
        check("t5_led", 32'(led), 32'd0);
        check("t5_ready", 32'(ready), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step();
        check("t5_ready_rel", 32'(ready), 32'd1);
        errs = 0;
        for (int c = 0; c < 1000; c++) begin
            if (led !== 1'b0 || busy !== 1'b0) errs++;
            step();
        end
        check("t5_no_stale", 32'(errs), 32'd0);
        check("t5_no_under", 32'(n_under - u0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
